// File: rtl/quadrature_mul_acc_window.sv
// quadrature_mul_acc_window: windowed ADC*SIN / ADC*COS correlator.
// The window spans whole ADC periods delimited by hysteretic rising zero-crossings.
module quadrature_mul_acc_window #(
  parameter int SIN_TABLE_DATA_WIDTH = 13,
  parameter int ADC_DATA_WIDTH       = 12,
  parameter int RESULT_WIDTH         = 32,
  parameter int DEPTH_BITS           = 4
) (
  input  logic                            CLK,
  input  logic                            RESET_N,
  input  logic                            CE,
  input  logic [SIN_TABLE_DATA_WIDTH-1:0] SIN_VALUE,
  input  logic [SIN_TABLE_DATA_WIDTH-1:0] COS_VALUE,
  input  logic [ADC_DATA_WIDTH-1:0]       ADC_VALUE,
  input  logic [ADC_DATA_WIDTH-2:0]       HYST,
  input  logic [DEPTH_BITS-1:0]           WINDOW,
  output logic [RESULT_WIDTH-1:0]         SIN_RESULT,
  output logic [RESULT_WIDTH-1:0]         COS_RESULT,
  output logic                            OUT_VALID,
  output logic                            ZERO_CROSS
);
  localparam int PW = SIN_TABLE_DATA_WIDTH + ADC_DATA_WIDTH;
  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_NEG  = 2'd1;
  localparam logic [1:0] S_POS  = 2'd2;
  localparam logic [DEPTH_BITS:0] FULL = {1'b1, {DEPTH_BITS{1'b0}}};

  logic signed [PW-1:0]           sin_prod_q, cos_prod_q;
  logic signed [RESULT_WIDTH-1:0] sin_acc_q, cos_acc_q;
  logic [RESULT_WIDTH-1:0]        sin_res_q, cos_res_q;
  logic [RESULT_WIDTH-1:0]        sin_buf [1<<DEPTH_BITS];
  logic [RESULT_WIDTH-1:0]        cos_buf [1<<DEPTH_BITS];
  logic [1:0]                     state_q, state_d;
  logic                           cross_q, cross_d, zc_q, valid_q;
  logic [DEPTH_BITS-1:0]          wp_q, win_q, rd_idx;
  logic [DEPTH_BITS:0]            fill_q, fill_d;
  logic signed [ADC_DATA_WIDTH-1:0] adc, hys;
  logic                           above, below, win_chg, fire;

  assign adc = $signed(ADC_VALUE);
  assign hys = $signed({1'b0, HYST});

  always_comb begin
    above   = adc > hys;
    below   = adc < -hys;
    state_d = above ? S_POS : below ? S_NEG : state_q;
    cross_d = above && state_q == S_NEG;
    win_chg = WINDOW != win_q;
    // fill counts snapshots taken before this one, so > WINDOW means WINDOW+1 periods back exist
    fire    = zc_q && !win_chg && fill_q > {1'b0, WINDOW};
    rd_idx  = wp_q - WINDOW - DEPTH_BITS'(1);
    fill_d  = win_chg ? (DEPTH_BITS+1)'(1) : fill_q == FULL ? fill_q : fill_q + (DEPTH_BITS+1)'(1);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sin_prod_q <= '0;
      cos_prod_q <= '0;
      sin_acc_q  <= '0;
      cos_acc_q  <= '0;
      sin_res_q  <= '0;
      cos_res_q  <= '0;
      state_q    <= S_INIT;
      cross_q    <= 1'b0;
      zc_q       <= 1'b0;
      valid_q    <= 1'b0;
      wp_q       <= '0;
      win_q      <= '0;
      fill_q     <= '0;
    end else begin
      valid_q <= CE && fire;
      if (CE) begin
        sin_prod_q <= $signed(SIN_VALUE) * adc;
        cos_prod_q <= $signed(COS_VALUE) * adc;
        sin_acc_q  <= sin_acc_q + RESULT_WIDTH'(sin_prod_q);
        cos_acc_q  <= cos_acc_q + RESULT_WIDTH'(cos_prod_q);
        state_q    <= state_d;
        cross_q    <= cross_d;
        zc_q       <= cross_q;
        if (zc_q) begin
          wp_q   <= wp_q + DEPTH_BITS'(1);
          win_q  <= WINDOW;
          fill_q <= fill_d;
        end
        if (fire) begin
          sin_res_q <= sin_acc_q - sin_buf[rd_idx];
          cos_res_q <= cos_acc_q - cos_buf[rd_idx];
        end
      end
    end
  end

  // snapshot memory is not reset; FILL guards against reading stale entries
  always_ff @(posedge CLK) begin
    if (CE && zc_q) begin
      sin_buf[wp_q] <= sin_acc_q;
      cos_buf[wp_q] <= cos_acc_q;
    end
  end

  assign SIN_RESULT = sin_res_q;
  assign COS_RESULT = cos_res_q;
  assign OUT_VALID  = valid_q;
  assign ZERO_CROSS = zc_q;
endmodule

// File: tb/tb_quadrature_mul_acc_window.sv
// tb_quadrature_mul_acc_window: scoreboard bench for the windowed quadrature correlator.
// A second instance with 20-bit results checks modulo wrap-around.
module tb_quadrature_mul_acc_window;
  typedef struct {logic [31:0] s; logic [31:0] c; int due;} exp_t;
  typedef struct {logic [19:0] s; logic [19:0] c; int due;} exp_w_t;

  logic        clk = 1'b0;
  logic        rst_n, rst_w_n, ce;
  logic [12:0] sin_v, cos_v;
  logic [11:0] adc;
  logic [10:0] hyst;
  logic [3:0]  window;
  logic [31:0] sin_res, cos_res;
  logic [19:0] sin_w, cos_w;
  logic        out_valid, zero_cross, valid_w, zc_w;

  exp_t   q[$];
  exp_w_t qw[$];
  int checks = 0, errors = 0, ce_cnt = 0, zc_cnt = 0;
  bit gl = 0, z = 0, gp = 0, wrap_en = 0;

  quadrature_mul_acc_window dut (
    .CLK(clk), .RESET_N(rst_n), .CE(ce), .SIN_VALUE(sin_v), .COS_VALUE(cos_v),
    .ADC_VALUE(adc), .HYST(hyst), .WINDOW(window), .SIN_RESULT(sin_res),
    .COS_RESULT(cos_res), .OUT_VALID(out_valid), .ZERO_CROSS(zero_cross)
  );

  quadrature_mul_acc_window #(.RESULT_WIDTH(20)) dut_w (
    .CLK(clk), .RESET_N(rst_w_n), .CE(ce), .SIN_VALUE(sin_v), .COS_VALUE(cos_v),
    .ADC_VALUE(adc), .HYST(hyst), .WINDOW(window), .SIN_RESULT(sin_w),
    .COS_RESULT(cos_w), .OUT_VALID(valid_w), .ZERO_CROSS(zc_w)
  );

  always #5 clk = ~clk;

  // advance one clock and retire any strobe against the scoreboard
  task automatic tick();
    bit ce_e;
    exp_t e;
    exp_w_t ew;
    ce_e = ce;
    @(posedge clk);
    if (ce_e) ce_cnt++;
    #1;
    if (ce_e && zero_cross) zc_cnt++;
    if (out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected sin=%0d cos=%0d ce=%0d", $signed(sin_res), $signed(cos_res), ce_cnt);
      end else begin
        e = q.pop_front();
        if (sin_res !== e.s || cos_res !== e.c || ce_cnt != e.due) begin
          errors++;
          $display("FAIL strobe got sin=%0d cos=%0d ce=%0d want sin=%0d cos=%0d ce=%0d",
                   $signed(sin_res), $signed(cos_res), ce_cnt, $signed(e.s), $signed(e.c), e.due);
        end
      end
    end
    if (valid_w) begin
      checks++;
      if (qw.size() == 0) begin
        errors++;
        $display("FAIL wrap_strobe_unexpected sin=%0d cos=%0d", $signed(sin_w), $signed(cos_w));
      end else begin
        ew = qw.pop_front();
        if (sin_w !== ew.s || cos_w !== ew.c || ce_cnt != ew.due) begin
          errors++;
          $display("FAIL wrap_strobe got sin=%0d cos=%0d ce=%0d want sin=%0d cos=%0d ce=%0d",
                   $signed(sin_w), $signed(cos_w), ce_cnt, $signed(ew.s), $signed(ew.c), ew.due);
        end
      end
    end
  endtask

  task automatic smp(int a, int s, int c, bit push, int es, int ec);
    adc   = a[11:0];
    sin_v = s[12:0];
    cos_v = c[12:0];
    ce    = 1'b1;
    if (push) begin
      q.push_back('{s: 32'(es), c: 32'(ec), due: ce_cnt + 3});
      if (wrap_en) qw.push_back('{s: es[19:0], c: ec[19:0], due: ce_cnt + 3});
    end
    tick();
  endtask

  task automatic gap(int n);
    ce = 1'b0;
    for (int i = 0; i < n; i++) begin
      adc   = 12'($urandom);
      sin_v = 13'($urandom);
      cos_v = 13'($urandom);
      tick();
    end
  endtask

  // one ADC period: 4 samples +1000 then 4 samples -1000, references in phase
  task automatic period(int s, int c, bit push, int es, int ec);
    smp(1000, s, c, push, es, ec);
    smp(1000, s, c, 0, 0, 0);
    smp(1000, s, c, 0, 0, 0);
    if (gp) gap(5);
    if (gl) begin smp(-5, 0, 0, 0, 0, 0); smp(-10, 0, 0, 0, 0, 0); end
    if (z) smp(0, 0, 0, 0, 0, 0);
    smp(1000, s, c, 0, 0, 0);
    smp(-1000, -s, -c, 0, 0, 0);
    if (gl) begin smp(5, 0, 0, 0, 0, 0); smp(10, 0, 0, 0, 0, 0); end
    if (z) smp(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) smp(-1000, -s, -c, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    zc_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sin_res, cos_res, out_valid, zero_cross} !== '0) begin
      errors++;
      $display("FAIL reset_initial sin=%0d cos=%0d valid=%b zc=%b want all 0", sin_res, cos_res, out_valid, zero_cross);
    end
    tick();
    rst_n = 1'b1;
    hyst = 11'd10;
    window = 4'd0;
    period(100, 0, 0, 0, 0);
    period(100, 0, 0, 0, 0);
    period(100, 0, 1, 800000, 0);
    smp(-1000, -100, 0, 0, 0, 0);
    smp(-1000, -100, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (sin_res !== 32'd0 || cos_res !== 32'd0 || out_valid !== 1'b0 || zero_cross !== 1'b0) begin
      errors++;
      $display("FAIL reset_async sin=%0d cos=%0d valid=%b zc=%b want all 0", sin_res, cos_res, out_valid, zero_cross);
    end
    tick();
    rst_n = 1'b1;
    period(100, 0, 0, 0, 0);
    period(100, 0, 0, 0, 0);
    period(100, 0, 1, 800000, 0);
    checks++;
    if (sin_res !== 32'd800000) begin
      errors++;
      $display("FAIL reset_recover sin=%0d want 800000", $signed(sin_res));
    end
  endtask

  task automatic test_basic();
    do_reset();
    window = 4'd0;
    period(100, 0, 0, 0, 0);
    period(100, 0, 0, 0, 0);
    period(100, 0, 1, 800000, 0);
    period(100, 0, 1, 800000, 0);
    smp(-1000, -100, 0, 0, 0, 0);
    checks++;
    if (sin_res !== 32'd800000 || cos_res !== 32'd0) begin
      errors++;
      $display("FAIL basic_hold sin=%0d cos=%0d want 800000 0", $signed(sin_res), $signed(cos_res));
    end
  endtask

  task automatic test_window();
    do_reset();
    window = 4'd3;
    for (int i = 0; i < 8; i++) period(100, -20, i >= 5, 3200000, -640000);
  endtask

  task automatic test_ce_window_change();
    gp = 1;
    for (int i = 0; i < 2; i++) period(100, -20, 1, 3200000, -640000);
    gp = 0;
    window = 4'd1;
    period(100, -20, 0, 0, 0);
    period(100, -20, 0, 0, 0);
    period(100, -20, 1, 1600000, -320000);
    period(100, -20, 1, 1600000, -320000);
  endtask

  task automatic test_hysteresis();
    do_reset();
    window = 4'd0;
    hyst = 11'd10;
    gl = 1;
    for (int i = 0; i < 4; i++) period(100, 0, i >= 2, 800000, 0);
    gl = 0;
    checks++;
    if (zc_cnt != 3) begin
      errors++;
      $display("FAIL hyst_zero_cross count=%0d want 3", zc_cnt);
    end
    do_reset();
    hyst = 11'd0;
    z = 1;
    for (int i = 0; i < 4; i++) period(100, 0, i >= 2, 800000, 0);
    z = 0;
    checks++;
    if (zc_cnt != 3) begin
      errors++;
      $display("FAIL hyst0_zero_cross count=%0d want 3", zc_cnt);
    end
  endtask

  task automatic test_wrap();
    wrap_en = 1;
    hyst = 11'd10;
    window = 4'd0;
    do_reset();
    rst_w_n = 1'b1;
    for (int i = 0; i < 8; i++) period(50, -30, i >= 2, 400000, -240000);
    wrap_en = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    rst_w_n = 1'b0;
    ce = 1'b0;
    adc = '0;
    sin_v = '0;
    cos_v = '0;
    hyst = 11'd10;
    window = '0;
    test_reset();
    test_basic();
    test_window();
    test_ce_window_change();
    test_hysteresis();
    test_wrap();
    ce = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes pending=%0d want 0", q.size());
    end
    checks++;
    if (qw.size() != 0) begin
      errors++;
      $display("FAIL missing_wrap_strobes pending=%0d want 0", qw.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/quadrature_mul_acc_window.md
QUADRATURE_MUL_ACC_WINDOW -- requirements
Module: quadrature_mul_acc_window

Interface
REQ-001 SHALL have parameter SIN_TABLE_DATA_WIDTH, default 13, signed SIN/COS table sample width.
REQ-002 SHALL have parameter ADC_DATA_WIDTH, default 12, signed ADC sample width.
REQ-003 SHALL have parameter RESULT_WIDTH, default 32, accumulator and result width.
REQ-004 SHALL have parameter DEPTH_BITS, default 4, snapshot buffer depth of 2^DEPTH_BITS entries.
REQ-005 SHALL have port CLK  in  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port CE  in  1  clock enable; 0 freezes all state except OUT_VALID clear.
REQ-008 SHALL have port SIN_VALUE  in  SIN_TABLE_DATA_WIDTH  signed sine reference.
REQ-009 SHALL have port COS_VALUE  in  SIN_TABLE_DATA_WIDTH  signed cosine reference.
REQ-010 SHALL have port ADC_VALUE  in  ADC_DATA_WIDTH  signed ADC sample.
REQ-011 SHALL have port HYST  in  ADC_DATA_WIDTH-1  unsigned zero-cross hysteresis threshold.
REQ-012 SHALL have port WINDOW  in  DEPTH_BITS  window length minus 1, in ADC periods.
REQ-013 SHALL have port SIN_RESULT  out  RESULT_WIDTH  signed ADC*SIN sum over the window.
REQ-014 SHALL have port COS_RESULT  out  RESULT_WIDTH  signed ADC*COS sum over the window.
REQ-015 SHALL have port OUT_VALID  out  1  one-cycle strobe; results updated.
REQ-016 SHALL have port ZERO_CROSS  out  1  registered rising-crossing flag, pipeline-aligned to snapshot.

Function
REQ-017 SHALL, on each CE=1 edge, register products SIN_VALUE*ADC_VALUE and COS_VALUE*ADC_VALUE (stage 1), full-precision signed.
REQ-018 SHALL add the sign-extended stage-1 products into the SIN/COS accumulators on the next CE=1 edge (stage 2), modulo 2^RESULT_WIDTH, never saturating.
REQ-019 SHALL run a crossing FSM on each CE=1 sample: states INIT, NEG, POS.
REQ-020 SHALL transition INIT->NEG when ADC < -HYST and INIT->POS when ADC > +HYST, with no crossing flagged; comparisons are strict and signed.
REQ-021 SHALL transition NEG->POS when ADC > +HYST, flagging a rising crossing for that sample; POS->NEG when ADC < -HYST, no flag; otherwise hold state.
REQ-022 SHALL delay the crossing flag so it coincides with the accumulator value that includes the crossing sample's products; ZERO_CROSS is that aligned flag.
REQ-023 SHALL, on each aligned crossing, write the accumulator pair to a circular buffer at write pointer WP, then increment WP modulo 2^DEPTH_BITS.
REQ-024 SHALL keep fill count FILL (entries written since reset/clear), saturating at 2^DEPTH_BITS.
REQ-025 SHALL, on an aligned crossing with FILL >= WINDOW+1, load SIN_RESULT/COS_RESULT with current accumulator minus buffer[WP-WINDOW-1] (modulo 2^RESULT_WIDTH) and assert OUT_VALID on the following cycle.
REQ-026 SHALL assert OUT_VALID for exactly one CLK cycle, 3 CE=1 edges after the crossing sample was presented; OUT_VALID clears on the next edge regardless of CE.
REQ-027 SHALL hold SIN_RESULT/COS_RESULT unchanged between strobes.
REQ-028 SHALL register WINDOW at each aligned crossing; if it differs from the previous registered value, FILL clears to 1 (current snapshot only) and no strobe is produced for that crossing.
REQ-029 SHALL treat CE=0 cycles as absent: no sample, FSM, accumulator, buffer or pointer change.
REQ-030 SHALL, with HYST=0, behave as a plain sign-change detector excluding ADC=0 as a crossing trigger.

Reset
REQ-031 SHALL, on RESET_N=0, asynchronously clear accumulators, product registers, buffer pointer, FILL, SIN_RESULT, COS_RESULT, OUT_VALID, ZERO_CROSS to 0 and FSM to INIT; buffer contents need not be cleared.
REQ-032 SHALL, after RESET_N deasserts mid-operation, require a fresh INIT->NEG->POS sequence before the first crossing.

Verification
REQ-033 SHALL verify reset: RESET_N low mid-window -> all outputs 0 same cycle; no OUT_VALID until 2 rising crossings after release (WINDOW=0).
REQ-034 SHALL verify basic sum: ADC 4 samples +1000 / 4 samples -1000, SIN=+100/-100 in phase, COS=0, HYST=10, WINDOW=0 -> 2nd crossing strobes SIN_RESULT=800000, COS_RESULT=0.
REQ-035 SHALL verify window: same stimulus, WINDOW=3 -> first strobe at 5th crossing, SIN_RESULT=3200000, then one strobe per period with the same value.
REQ-036 SHALL verify hysteresis: HYST=10, ±5 glitches inside a half-period -> no extra ZERO_CROSS, results unchanged.
REQ-037 SHALL verify wrap: RESULT_WIDTH=20, SIN=±50 -> accumulators wrap yet SIN_RESULT=400000 every period.
REQ-038 SHALL verify CE gaps and WINDOW change: CE=0 for 5 cycles mid-period -> identical results; WINDOW 3->1 -> next strobe only after 2 further crossings.
